// File: rtl/audio_mixer.sv
// rtl/audio_mixer.sv - stereo PSG/PCM mixer with serial 4-bit gain MAC and 17-bit saturation
module audio_mixer (
    input  logic        clk,
    input  logic        rst,
    input  logic        next_sample,
    input  logic [15:0] psg_left,
    input  logic [15:0] psg_right,
    input  logic [15:0] pcm_left,
    input  logic [15:0] pcm_right,
    input  logic [3:0]  psg_gain,
    input  logic [3:0]  pcm_gain,
    input  logic        status_clear,
    output logic [23:0] left_data,
    output logic [23:0] right_data,
    output logic        sample_valid,
    output logic        busy,
    output logic        clip_left,
    output logic        clip_right,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;

    localparam logic signed [20:0] SAT_MAX = 21'sd65535;
    localparam logic signed [20:0] SAT_MIN = -21'sd65536;

    state_t             state;
    state_t             state_next;
    logic               capture;
    logic [2:0]         k;
    logic [15:0]        psg_l_q, psg_r_q, pcm_l_q, pcm_r_q;
    logic [3:0]         psg_g_q, pcm_g_q;
    logic signed [20:0] acc_l, acc_r;
    logic [15:0]        src_l, src_r;
    logic [3:0]         gain;
    logic signed [20:0] add_l, add_r;
    logic signed [20:0] sh_l, sh_r;
    logic [16:0]        sat_l, sat_r;
    logic               clip_l_now, clip_r_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (next_sample) begin
                    capture    = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                busy = 1'b1;
                if (k == 3'd7) begin
                    state_next = SAT;
                end
            end
            SAT: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Steps 0-3 walk the PSG gain bits, steps 4-7 the PCM gain bits.
    always_comb begin
        src_l = k[2] ? pcm_l_q : psg_l_q;
        src_r = k[2] ? pcm_r_q : psg_r_q;
        gain  = k[2] ? pcm_g_q : psg_g_q;
        add_l = '0;
        add_r = '0;
        if (gain[k[1:0]]) begin
            add_l = 21'($signed(src_l)) <<< k[1:0];
            add_r = 21'($signed(src_r)) <<< k[1:0];
        end
    end

    always_comb begin
        sh_l       = acc_l >>> 3;
        sh_r       = acc_r >>> 3;
        clip_l_now = (sh_l > SAT_MAX) || (sh_l < SAT_MIN);
        clip_r_now = (sh_r > SAT_MAX) || (sh_r < SAT_MIN);
        sat_l      = (sh_l > SAT_MAX) ? 17'h0FFFF : (sh_l < SAT_MIN) ? 17'h10000 : sh_l[16:0];
        sat_r      = (sh_r > SAT_MAX) ? 17'h0FFFF : (sh_r < SAT_MIN) ? 17'h10000 : sh_r[16:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k            <= '0;
            psg_l_q      <= '0;
            psg_r_q      <= '0;
            pcm_l_q      <= '0;
            pcm_r_q      <= '0;
            psg_g_q      <= '0;
            pcm_g_q      <= '0;
            acc_l        <= '0;
            acc_r        <= '0;
            left_data    <= '0;
            right_data   <= '0;
            sample_valid <= 1'b0;
            clip_left    <= 1'b0;
            clip_right   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (capture) begin
                psg_l_q <= psg_left;
                psg_r_q <= psg_right;
                pcm_l_q <= pcm_left;
                pcm_r_q <= pcm_right;
                psg_g_q <= psg_gain;
                pcm_g_q <= pcm_gain;
                acc_l   <= '0;
                acc_r   <= '0;
                k       <= '0;
            end
            if (state == MAC) begin
                acc_l <= acc_l + add_l;
                acc_r <= acc_r + add_r;
                k     <= k + 3'd1;
            end
            if (state == SAT) begin
                left_data    <= {sat_l, 7'b0};
                right_data   <= {sat_r, 7'b0};
                sample_valid <= 1'b1;
            end
            // A set event in the same cycle as status_clear keeps the flag high.
            clip_left  <= (clip_left & ~status_clear) | ((state == SAT) & clip_l_now);
            clip_right <= (clip_right & ~status_clear) | ((state == SAT) & clip_r_now);
            overrun    <= (overrun & ~status_clear) | (next_sample & busy);
        end
    end
endmodule
